// File: rtl/code_ram_loader.sv
// Instruction-store RAM with a registered 1-cycle fetch port and a streaming valid/ready loader.
// Optional per-word even parity is enabled with `define CODE_RAM_PARITY_EN.
module code_ram_loader #(
   parameter int DW = 32,
   parameter int AW = 7
) (
   input  logic          mclk,
   input  logic          rst,
   input  logic          fetch_en,
   input  logic [AW-1:0] fetch_addr,
   output logic [DW-1:0] fetch_data,
   output logic          fetch_valid,
   output logic          fetch_perr,
   input  logic          ld_start,
   input  logic [AW-1:0] ld_base,
   input  logic [AW:0]   ld_len,
   input  logic          ld_valid,
   input  logic [DW-1:0] ld_data,
   output logic          ld_ready,
   output logic          ld_busy,
   output logic          ld_done,
   output logic [AW-1:0] ld_wptr,
   input  logic          par_inj
);

   localparam int DEPTH = 2**AW;
`ifdef CODE_RAM_PARITY_EN
   localparam int MW = DW + 1;
`else
   localparam int MW = DW;
`endif

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t        state;
   logic [AW:0]   remain;
   logic [MW-1:0] mem [DEPTH];
   logic          wr_en;
   logic [MW-1:0] wr_word;

   assign wr_en = (state == LOAD) && ld_valid && !rst;

`ifdef CODE_RAM_PARITY_EN
   assign wr_word = {(^ld_data) ^ par_inj, ld_data};
`else
   assign wr_word = ld_data;
`endif

   // Loader FSM; ld_ready/ld_busy/ld_done are registered alongside the state.
   always_ff @(posedge mclk) begin
      if (rst) begin
         state    <= IDLE;
         remain   <= '0;
         ld_wptr  <= '0;
         ld_ready <= 1'b0;
         ld_busy  <= 1'b0;
         ld_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ld_done <= 1'b0;
               if (ld_start) begin
                  ld_wptr <= ld_base;
                  remain  <= ld_len;
                  ld_busy <= 1'b1;
                  if (ld_len == '0) begin
                     state   <= DONE;
                     ld_done <= 1'b1;
                  end else begin
                     state    <= LOAD;
                     ld_ready <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (ld_valid) begin
                  ld_wptr <= ld_wptr + AW'(1);
                  remain  <= remain - (AW+1)'(1);
                  if (remain == (AW+1)'(1)) begin
                     state    <= DONE;
                     ld_ready <= 1'b0;
                     ld_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state   <= IDLE;
               ld_done <= 1'b0;
               ld_busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the storage array has no reset; clearing it would forbid RAM inference and
   // the contents must survive a reset that aborts a load.
   always_ff @(posedge mclk) begin
      if (wr_en) mem[ld_wptr] <= wr_word;
   end

   // NOTE: non-blocking read of mem in the same edge as a write sees the old word,
   // which gives read-first behaviour on a same-address collision.
   always_ff @(posedge mclk) begin
      if (rst) begin
         fetch_data  <= '0;
         fetch_valid <= 1'b0;
      end else begin
         fetch_valid <= fetch_en;
         if (fetch_en) fetch_data <= mem[fetch_addr][DW-1:0];
      end
   end

`ifdef CODE_RAM_PARITY_EN
   always_ff @(posedge mclk) begin
      if (rst) fetch_perr <= 1'b0;
      else     fetch_perr <= fetch_en && (mem[fetch_addr][DW] != ^mem[fetch_addr][DW-1:0]);
   end
`else
   logic unused_par_inj;
   assign unused_par_inj = par_inj;
   assign fetch_perr     = 1'b0;
`endif

endmodule

// File: tb/tb_code_ram_loader.sv
// Randomized self-checking bench for code_ram_loader against an array/transaction model.
// Define CODE_RAM_PARITY_EN for both RTL and bench to exercise the parity option.
module tb_code_ram_loader;

   localparam int DW    = 32;
   localparam int AW    = 7;
   localparam int DEPTH = 2**AW;

   logic          mclk = 1'b0;
   logic          rst;
   logic          fetch_en;
   logic [AW-1:0] fetch_addr;
   logic [DW-1:0] fetch_data;
   logic          fetch_valid;
   logic          fetch_perr;
   logic          ld_start;
   logic [AW-1:0] ld_base;
   logic [AW:0]   ld_len;
   logic          ld_valid;
   logic [DW-1:0] ld_data;
   logic          ld_ready;
   logic          ld_busy;
   logic          ld_done;
   logic [AW-1:0] ld_wptr;
   logic          par_inj;

   code_ram_loader #(.DW(DW), .AW(AW)) dut (
      .mclk(mclk), .rst(rst),
      .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
      .fetch_valid(fetch_valid), .fetch_perr(fetch_perr),
      .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
      .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
      .ld_busy(ld_busy), .ld_done(ld_done), .ld_wptr(ld_wptr),
      .par_inj(par_inj)
   );

   always #5 mclk = ~mclk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] ref_mem [DEPTH];
   bit          ref_wr  [DEPTH];
   bit          ref_inj [DEPTH];
   logic [31:0] last_fd = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic exp_perr(input int a);
`ifdef CODE_RAM_PARITY_EN
      return ref_inj[a];
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic fetch(input int a);
      logic [31:0] ed;
      logic        ep;
      fetch_addr = AW'(a);
      fetch_en   = 1'b1;
      ed = ref_mem[a];
      ep = exp_perr(a);
      tick();
      fetch_en = 1'b0;
      check("fetch_valid", 32'(fetch_valid), 32'(1));
      check($sformatf("fetch_data@%0d", a), fetch_data, ed);
      check("fetch_perr", 32'(fetch_perr), 32'(ep));
      last_fd = ed;
   endtask

   // Loads len words at base; random gaps carry ignored ld_start pulses; optional same-edge fetch.
   task automatic load(input int base, input int len, input int max_gap, input bit collide);
      int          a;
      int          gaps;
      bit          fetched;
      logic [31:0] d;
      logic [31:0] ed;
      logic        ep;
      bit          inj;
      ld_base  = AW'(base);
      ld_len   = (AW+1)'(len);
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      check("busy_after_start", 32'(ld_busy), 32'(1));
      if (len == 0) begin
         check("done_len0", 32'(ld_done), 32'(1));
         check("ready_len0", 32'(ld_ready), 32'(0));
         check("wptr_len0", 32'(ld_wptr), 32'(base));
         tick();
         check("done_len0_clr", 32'(ld_done), 32'(0));
         check("busy_len0_clr", 32'(ld_busy), 32'(0));
         return;
      end
      check("ready_after_start", 32'(ld_ready), 32'(1));
      check("wptr_after_start", 32'(ld_wptr), 32'(base));
      for (int i = 0; i < len; i++) begin
         gaps = int'($urandom_range(0, max_gap));
         for (int g = 0; g < gaps; g++) begin
            ld_valid = 1'b0;
            ld_start = 1'($urandom_range(0, 1));
            ld_base  = AW'($urandom);
            ld_len   = (AW+1)'($urandom);
            tick();
            ld_start = 1'b0;
            check("wptr_stall", 32'(ld_wptr), 32'((base + i) % DEPTH));
            check("ready_stall", 32'(ld_ready), 32'(1));
            check("done_stall", 32'(ld_done), 32'(0));
            check("fv_idle", 32'(fetch_valid), 32'(0));
            check("fd_hold", fetch_data, last_fd);
         end
         a       = (base + i) % DEPTH;
         d       = $urandom;
         inj     = 1'($urandom_range(0, 1));
         fetched = collide && ref_wr[a];
         ed      = ref_mem[a];
         ep      = exp_perr(a);
         ld_valid = 1'b1;
         ld_data  = d;
         par_inj  = inj;
         if (fetched) begin
            fetch_en   = 1'b1;
            fetch_addr = AW'(a);
         end
         tick();
         ld_valid   = 1'b0;
         par_inj    = 1'b0;
         fetch_en   = 1'b0;
         ref_mem[a] = d;
         ref_wr[a]  = 1'b1;
         ref_inj[a] = inj;
         if (fetched) begin
            check("collide_old", fetch_data, ed);
            check("collide_perr", 32'(fetch_perr), 32'(ep));
            last_fd = ed;
         end
         check("wptr_inc", 32'(ld_wptr), 32'((base + i + 1) % DEPTH));
         check("done_pulse", 32'(ld_done), 32'(i == len - 1));
         check("ready_xfer", 32'(ld_ready), 32'(i != len - 1));
      end
      tick();
      check("done_clr", 32'(ld_done), 32'(0));
      check("busy_clr", 32'(ld_busy), 32'(0));
      check("wptr_end", 32'(ld_wptr), 32'((base + len) % DEPTH));
   endtask

   int last_addr;

   initial begin
      rst = 1'b1; fetch_en = 1'b0; fetch_addr = '0; ld_start = 1'b0; ld_base = '0;
      ld_len = '0; ld_valid = 1'b0; ld_data = '0; par_inj = 1'b0;
      tick();
      tick();
      check("rst_fd", fetch_data, 32'(0));
      check("rst_fv", 32'(fetch_valid), 32'(0));
      check("rst_perr", 32'(fetch_perr), 32'(0));
      check("rst_ready", 32'(ld_ready), 32'(0));
      check("rst_busy", 32'(ld_busy), 32'(0));
      check("rst_done", 32'(ld_done), 32'(0));
      check("rst_wptr", 32'(ld_wptr), 32'(0));
      rst = 1'b0;
      tick();

      // Basic load with stalls, then read back
      load(5, 3, 2, 1'b0);
      for (int a = 5; a < 8; a++) fetch(a);

      // Address wrap and zero-length load
      load(126, 4, 1, 1'b0);
      fetch(126); fetch(127); fetch(0); fetch(1);
      load(20, 0, 0, 1'b0);

      // Same-edge read/write collision returns old data, then new data
      load(10, 1, 0, 1'b0);
      load(10, 1, 0, 1'b1);
      fetch(10);
      load(50, 4, 3, 1'b0);
      load(50, 4, 3, 1'b1);

      // Reset after 2 of 4 words
      load(40, 4, 0, 1'b0);
      ld_base = AW'(40); ld_len = (AW+1)'(4); ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1; ld_data = $urandom;
         tick();
         ref_mem[40 + i] = ld_data;
         ref_inj[40 + i] = 1'b0;
      end
      ld_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_fd = '0;
      check("abort_busy", 32'(ld_busy), 32'(0));
      check("abort_ready", 32'(ld_ready), 32'(0));
      check("abort_done", 32'(ld_done), 32'(0));
      check("abort_wptr", 32'(ld_wptr), 32'(0));
      check("abort_fd", fetch_data, 32'(0));
      tick();
      check("abort_no_done", 32'(ld_done), 32'(0));
      for (int a = 40; a < 44; a++) fetch(a);

      // Full-depth load ends with wptr back at base
      load(77, DEPTH, 0, 1'b1);
      for (int k = 0; k < 4; k++) fetch(int'($urandom_range(0, DEPTH - 1)));

      // Random loads and fetches
      last_addr = 77;
      for (int it = 0; it < 40; it++) begin
         int b;
         int l;
         b = int'($urandom_range(0, DEPTH - 1));
         l = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 10));
         load(b, l, 2, 1'($urandom_range(0, 1)));
         for (int k = 0; k < 3; k++) begin
            int a;
            a = int'($urandom_range(0, DEPTH - 1));
            if (!ref_wr[a]) a = last_addr;
            last_addr = a;
            fetch(a);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
